// File: rtl/start_thermo_decoder.sv
// Start-channel thermometer decoder: edge detect, bubble fix,
// pipelined popcount and coarse-time pairing for the TDC readout.
module start_thermo_decoder #(
    parameter int NFF     = 176,
    parameter int FINEW   = 8,
    parameter int COARSEW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NFF-1:0]     therm_in,
    input  logic               arm,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [FINEW-1:0]   fine_out,
    output logic [COARSEW-1:0] coarse_out,
    output logic               sat_err,
    output logic               armed
);

    localparam int LO = NFF / 2;
    localparam int HI = NFF - LO;
    localparam int HW = $clog2(HI + 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CONV,
        HOLD
    } state_t;

    state_t             state;
    logic [1:0]         cnt;
    logic [COARSEW-1:0] ctr;
    logic [COARSEW-1:0] coarse_q;
    logic               prev0;
    logic [NFF+1:0]     ext;
    logic [NFF-1:0]     corr;
    logic [NFF-1:0]     s1;
    logic [HW-1:0]      s2_lo;
    logic [HW-1:0]      s2_hi;
    logic [FINEW-1:0]   sum;
    logic               hit;

    function automatic logic [HW-1:0] popcnt(input logic [HI-1:0] v);
        logic [HW-1:0] n;
        n = '0;
        for (int i = 0; i < HI; i++) begin
            n = n + HW'(v[i]);
        end
        return n;
    endfunction

    // Pad below with 1 and above with 0 so the ends vote sensibly
    assign ext = {1'b0, therm_in, 1'b1};

    for (genvar i = 0; i < NFF; i++) begin : g_maj
        assign corr[i] = (ext[i] & ext[i+1]) |
                         (ext[i] & ext[i+2]) |
                         (ext[i+1] & ext[i+2]);
    end

    assign hit = (state == ARMED) && therm_in[0] && !prev0;
    assign sum = FINEW'(s2_lo) + FINEW'(s2_hi);

    // Free-running coarse time and bit-0 history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr   <= '0;
            prev0 <= 1'b0;
        end else begin
            ctr   <= ctr + COARSEW'(1);
            prev0 <= therm_in[0];
        end
    end

    // Capture stage and partial popcount stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= '0;
            coarse_q <= '0;
            s2_lo    <= '0;
            s2_hi    <= '0;
        end else begin
            if (hit) begin
                s1       <= corr;
                coarse_q <= ctr;
            end
            if (state == CONV) begin
                s2_lo <= popcnt(HI'(s1[LO-1:0]));
                s2_hi <= popcnt(s1[NFF-1:LO]);
            end
        end
    end

    // Measurement sequencing with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            armed      <= 1'b0;
            out_valid  <= 1'b0;
            fine_out   <= '0;
            coarse_out <= '0;
            sat_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arm) begin
                        state <= ARMED;
                        armed <= 1'b1;
                    end
                end
                ARMED: begin
                    if (hit) begin
                        state <= CONV;
                        cnt   <= 2'd1;
                        armed <= 1'b0;
                    end
                end
                CONV: begin
                    if (cnt == 2'd2) begin
                        state      <= HOLD;
                        cnt        <= '0;
                        out_valid  <= 1'b1;
                        fine_out   <= sum;
                        coarse_out <= coarse_q;
                        sat_err    <= (sum == FINEW'(NFF));
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_start_thermo_decoder.sv
// Self-checking bench for start_thermo_decoder.
// Behavioural model tracks measurements as timed events.
module tb_start_thermo_decoder;

    localparam int NFF     = 176;
    localparam int FINEW   = 8;
    localparam int COARSEW = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NFF-1:0]     therm_in = '0;
    logic               arm = 1'b0;
    logic               out_ready = 1'b0;
    logic               out_valid;
    logic [FINEW-1:0]   fine_out;
    logic [COARSEW-1:0] coarse_out;
    logic               sat_err;
    logic               armed;

    int checks = 0;
    int failures = 0;

    start_thermo_decoder #(
        .NFF(NFF), .FINEW(FINEW), .COARSEW(COARSEW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .therm_in(therm_in),
        .arm(arm),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .fine_out(fine_out),
        .coarse_out(coarse_out),
        .sat_err(sat_err),
        .armed(armed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Count of positions where at least two of the three
    // neighbouring taps are set (ends padded 1 below, 0 above)
    function automatic int ref_count(input logic [NFF-1:0] t);
        int n;
        int v;
        n = 0;
        for (int i = 0; i < NFF; i++) begin
            v = int'(t[i]);
            if (i == 0) v += 1;
            else v += int'(t[i-1]);
            if (i < NFF - 1) v += int'(t[i+1]);
            if (v >= 2) n++;
        end
        return n;
    endfunction

    function automatic logic [NFF-1:0] ones(input int n);
        logic [NFF-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Model: 0 idle, 1 waiting for edge, 2 converting, 3 holding
    int          m_mode;
    int          m_left;
    logic        m_prev0;
    logic [15:0] m_cyc;
    int          p_fine;
    logic [15:0] p_coarse;
    logic        m_valid, m_sat, m_armed;
    logic [7:0]  m_fine;
    logic [15:0] m_coarse;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_left = 0; m_prev0 = 0; m_cyc = 0;
            p_fine = 0; p_coarse = 0;
            m_valid = 0; m_sat = 0; m_armed = 0;
            m_fine = 0; m_coarse = 0;
        end else begin
            if (m_mode == 3) begin
                if (out_ready) begin
                    m_mode = 0;
                    m_valid = 0;
                end
            end else if (m_mode == 2) begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 3;
                    m_valid = 1;
                    m_fine = 8'(p_fine);
                    m_coarse = p_coarse;
                    m_sat = (p_fine == NFF);
                end
            end else if (m_mode == 1) begin
                if (therm_in[0] && !m_prev0) begin
                    p_fine = ref_count(therm_in);
                    p_coarse = m_cyc;
                    m_mode = 2;
                    m_left = 2;
                end
            end else if (arm) begin
                m_mode = 1;
            end
            m_armed = (m_mode == 1);
            m_prev0 = therm_in[0];
            m_cyc = m_cyc + 16'd1;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("valid", out_valid, m_valid);
        chk("armed", armed, m_armed);
        chk("fine", fine_out, m_fine);
        chk("coarse", coarse_out, m_coarse);
        chk("sat", sat_err, m_sat);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        chk("valid_timeout", out_valid, 1);
    endtask

    task automatic measure(input logic [NFF-1:0] v, output int lat);
        int n;
        arm = 1; therm_in = '0;
        step();
        arm = 0;
        step();
        therm_in = v;
        step();
        wait_valid(n);
        lat = n + 1;
        therm_in = '0;
    endtask

    task automatic accept();
        out_ready = 1;
        step();
        chk("accept_drop", out_valid, 0);
        out_ready = 0;
    endtask

    initial begin
        int lat;
        int n;
        int k;
        logic [NFF-1:0] bub;

        step(); step(); step();
        chk("rst_valid", out_valid, 0);
        chk("rst_fine", fine_out, 0);
        chk("rst_coarse", coarse_out, 0);
        chk("rst_sat", sat_err, 0);
        chk("rst_armed", armed, 0);

        // Basic: arm in counter cycle 0, low in 1, hit in 2
        rst_n = 1; arm = 1; therm_in = '0;
        step();
        chk("armed_up", armed, 1);
        arm = 0;
        step();
        therm_in = ones(37);
        step();
        wait_valid(n);
        chk("basic_lat", n + 1, 3);
        chk("basic_fine", fine_out, 37);
        chk("basic_coarse", coarse_out, 16'h0002);
        chk("basic_sat", sat_err, 0);
        therm_in = '0;
        accept();

        // Bubble
        bub = ones(50);
        bub[47] = 1'b0;
        bub[52] = 1'b1;
        measure(bub, lat);
        chk("bubble_lat", lat, 3);
        chk("bubble_fine", fine_out, 50);
        chk("bubble_sat", sat_err, 0);
        accept();

        // Saturation
        measure(ones(NFF), lat);
        chk("sat_fine", fine_out, 176);
        chk("sat_flag", sat_err, 1);
        accept();

        // Backpressure with arm pulses and edges meanwhile
        measure(ones(20), lat);
        for (int i = 0; i < 10; i++) begin
            arm = (i == 2);
            therm_in = (i % 2 == 1) ? ones(5) : '0;
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_fine", fine_out, 20);
        end
        arm = 0; therm_in = '0;
        accept();
        for (int i = 0; i < 4; i++) begin
            therm_in = (i % 2 == 1) ? ones(7) : '0;
            step();
            chk("bp_nocap", out_valid, 0);
            chk("bp_idle", armed, 0);
        end
        therm_in = '0;
        measure(ones(64), lat);
        chk("rearm_fine", fine_out, 64);
        accept();

        // Arm with bit 0 already high
        therm_in = ones(10);
        step();
        arm = 1;
        step();
        arm = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("high_nocap", out_valid, 0);
            chk("high_armed", armed, 1);
        end
        therm_in = '0;
        step();
        therm_in = ones(12);
        step();
        wait_valid(n);
        chk("high_fine", fine_out, 12);
        therm_in = '0;
        accept();

        // Arm and edge together in idle: edge not captured
        step();
        arm = 1; therm_in = ones(8);
        step();
        arm = 0;
        step(); step();
        chk("same_nocap", out_valid, 0);
        therm_in = '0;
        step();
        therm_in = ones(9);
        step();
        wait_valid(n);
        chk("same_fine", fine_out, 9);
        therm_in = '0;
        accept();

        // Coarse wrap: hit while counter is 0xFFFF
        arm = 1;
        step();
        arm = 0;
        k = 0;
        while (m_cyc != 16'hFFFF && k < 70000) begin
            step();
            k++;
        end
        therm_in = ones(30);
        step();
        wait_valid(n);
        chk("wrap_coarse", coarse_out, 16'hFFFF);
        chk("wrap_fine", fine_out, 30);
        therm_in = '0;
        accept();

        // Reset during conversion
        arm = 1;
        step();
        arm = 0;
        step();
        therm_in = ones(40);
        step();
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_fine", fine_out, 0);
        chk("mid_rst_coarse", coarse_out, 0);
        chk("mid_rst_armed", armed, 0);
        @(negedge clk);
        rst_n = 1; therm_in = '0;
        for (int i = 0; i < 6; i++) begin
            therm_in = (i % 2 == 1) ? ones(40) : '0;
            step();
            chk("post_rst_idle", out_valid, 0);
        end
        therm_in = '0;
        measure(ones(33), lat);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_fine", fine_out, 33);
        accept();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
